stage_ex_md: RTL
================

# stage_ex_md

Multiply/divide unit of the execute stage. It runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and owns the HI/LO architectural registers (MTHI/MTLO write, MFHI/MFLO read). It sits beside the ALU in the execute stage, directly upstream of `stage_mem`. The `busy` output drives the decode-stage stall logic.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: execute stage holds a valid md instruction this cycle.
- `op` in `MD_OP_LEN`: `MD_OP_NONE`, `MD_OP_MULT`, `MD_OP_MULTU`, `MD_OP_DIV`, `MD_OP_DIVU`, `MD_OP_MTHI`, `MD_OP_MTLO`.
- `cancel` in 1: exception/interrupt taken this cycle; suppresses `start`.
- `a` in 32: rs operand.
- `b` in 32: rt operand.
- `busy` out 1: operation in flight.
- `hi` out 32: architectural HI, read by MFHI.
- `lo` out 32: architectural LO, read by MFLO.

## Operation

- States: IDLE, BUSY. Counter `cnt` is wide enough for `max(MULT_CYCLES, DIV_CYCLES)`.
- Accept rule: a start is accepted when `start && !cancel && state==IDLE && op!=MD_OP_NONE`.
- MULT/MULTU:
  - 64-bit product is computed at accept and held in internal `pend_hi`/`pend_lo`.
  - MULT treats `a`/`b` as signed; MULTU as unsigned.
  - `cnt <= MULT_CYCLES`, go to BUSY.
- DIV/DIVU:
  - `pend_lo` = quotient, truncated toward zero; `pend_hi` = remainder, sign of dividend (DIV).
  - DIVU is fully unsigned.
  - `cnt <= DIV_CYCLES`, go to BUSY.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (`b==0`), signed or unsigned: full DIV_CYCLES busy period; HI/LO left unchanged at commit.
- BUSY: `cnt` decrements each cycle. In the cycle with `cnt==1`, `hi/lo <= pend_hi/pend_lo` and state goes to IDLE.
- MTHI/MTLO: `hi <= a` (resp. `lo <= a`) on the accepting edge; `busy` never asserts.
- Start while BUSY: ignored, no state change. Upstream stall guarantees this never happens; the bench asserts it.
- `cancel` has no effect on an operation already in BUSY; it completes normally.

## Timing

- Reset: state IDLE, `busy`=0, `hi`=0, `lo`=0, `cnt`=0, pending registers 0.
- Reset in any state (including mid-BUSY) aborts the operation; outputs take reset values the following cycle.
- Accept at edge of cycle t:
  - `busy`=1 in cycles t+1 through t+N (N = MULT_CYCLES or DIV_CYCLES).
  - New `hi/lo` are visible in cycle t+N+1, the same cycle `busy` returns to 0.
- Back-to-back: a new start is accepted in cycle t+N+1.
- MTHI/MTLO accepted in cycle t are visible in cycle t+1.
- `busy`, `hi`, `lo` are registered outputs with no combinational path from inputs.
- Decode-side stall, owned by the hazard unit, not this block: stall an md/MFHI/MFLO instruction while `busy || (start && op is MULT/MULTU/DIV/DIVU)`.

## Structure

- `MD_OP_*` and `MD_OP_LEN` go in the shared `def.v` next to `MEM_TYPE_*`; 3-bit encoding, NONE=0.
- Single module, no sub-module. Arithmetic uses behavioural `*`, `/`, `%` on sign-extended operands at accept; the counter only models latency.

## Test plan

- Reset: assert `reset` 2 cycles → `busy`=0, `hi`=`lo`=0; a start issued during reset is ignored.
- MULT vs MULTU:
  - MULT a=0xFFFFFFFF, b=2 → busy exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV vs DIVU:
  - DIV a=0xFFFFFFF9 (−7), b=2 → busy exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV a=5, b=0 → busy 10 cycles, hi=0x11, lo=0x22.
- MTHI/MTLO/cancel:
  - MTHI a=0x1234 → hi=0x1234 next cycle, `busy` stays 0.
  - MULT with `cancel`=1 in the same cycle → `busy` stays 0, hi/lo unchanged.
- Reset mid-op: MULT accepted, `reset` in busy cycle 3 → next cycle `busy`=0, hi=lo=0; a following MULTU 3×4 completes normally with lo=12.

Source files
------------

// File: rtl/stage_ex_md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the md opcode encoding (3 bits, NONE=0) and FSM state type.
// Pure declarations; no logic, no latency, no flow control.
package stage_ex_md_pkg;

   localparam int MD_OP_LEN = 3;

   localparam logic [MD_OP_LEN-1:0] MD_OP_NONE  = 3'd0;
   localparam logic [MD_OP_LEN-1:0] MD_OP_MULT  = 3'd1;
   localparam logic [MD_OP_LEN-1:0] MD_OP_MULTU = 3'd2;
   localparam logic [MD_OP_LEN-1:0] MD_OP_DIV   = 3'd3;
   localparam logic [MD_OP_LEN-1:0] MD_OP_DIVU  = 3'd4;
   localparam logic [MD_OP_LEN-1:0] MD_OP_MTHI  = 3'd5;
   localparam logic [MD_OP_LEN-1:0] MD_OP_MTLO  = 3'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // True for the opcodes that occupy the unit for a multi-cycle period.
   function automatic logic md_is_long(input logic [MD_OP_LEN-1:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
             (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
   endfunction

endpackage

// File: rtl/stage_ex_md.sv
// Execute-stage multiply/divide unit owning the HI/LO architectural registers.
// Latency: MULT* MULT_CYCLES, DIV* DIV_CYCLES busy cycles; MTHI/MTLO visible next cycle.
// No backpressure input: upstream stalls on busy; starts while busy are ignored.
module stage_ex_md
   import stage_ex_md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MD_OP_LEN-1:0] op,
   input  logic                 cancel,
   input  logic [31:0]          a,
   input  logic [31:0]          b,
   output logic                 busy,
   output logic [31:0]          hi,
   output logic [31:0]          lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;

   logic             accept;
   logic [63:0]      prod_s;
   logic [63:0]      prod_u;
   logic [31:0]      div_q_s;
   logic [31:0]      div_r_s;
   logic [31:0]      div_q_u;
   logic [31:0]      div_r_u;
   logic             div_zero;

   assign accept   = start && !cancel && (state == ST_IDLE) && (op != MD_OP_NONE);
   assign div_zero = (b == 32'd0);

   // Full-precision results computed at accept; the counter only models latency.
   // Signed divide works on 33-bit operands so 0x80000000 / -1 yields 0x80000000, rem 0.
   assign prod_s  = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
   assign prod_u  = {32'd0, a} * {32'd0, b};
   assign div_q_s = 32'($signed({a[31], a}) / $signed({b[31], b}));
   assign div_r_s = 32'($signed({a[31], a}) % $signed({b[31], b}));
   assign div_q_u = a / b;
   assign div_r_u = a % b;

   // Control FSM: latch the result at accept, hold it for the latency period, then commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (md_is_long(op)) begin
                     busy  <= 1'b1;
                     state <= ST_BUSY;
                  end
                  case (op)
                     MD_OP_MULT: begin
                        pend_hi <= prod_s[63:32];
                        pend_lo <= prod_s[31:0];
                        cnt     <= CNT_W'(MULT_CYCLES);
                     end
                     MD_OP_MULTU: begin
                        pend_hi <= prod_u[63:32];
                        pend_lo <= prod_u[31:0];
                        cnt     <= CNT_W'(MULT_CYCLES);
                     end
                     MD_OP_DIV: begin
                        // Divide by zero commits the current HI/LO back unchanged.
                        pend_hi <= div_zero ? hi : div_r_s;
                        pend_lo <= div_zero ? lo : div_q_s;
                        cnt     <= CNT_W'(DIV_CYCLES);
                     end
                     MD_OP_DIVU: begin
                        pend_hi <= div_zero ? hi : div_r_u;
                        pend_lo <= div_zero ? lo : div_q_u;
                        cnt     <= CNT_W'(DIV_CYCLES);
                     end
                     MD_OP_MTHI: hi <= a;
                     MD_OP_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               // cancel and start are deliberately ignored while busy.
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  hi    <= pend_hi;
                  lo    <= pend_lo;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
